// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;

  // IDLE: loader may be granted. LD_RESP: loader ack cycle, loader ineligible.
  typedef enum logic {
    IDLE    = 1'b0,
    LD_RESP = 1'b1
  } arb_state_t;

  // Which port owns the memory this cycle.
  typedef logic [1:0] sel_t;
  localparam sel_t SEL_NONE = 2'd0;
  localparam sel_t SEL_CPU  = 2'd1;
  localparam sel_t SEL_LD   = 2'd2;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating count of cycles the loader was eligible but lost to the CPU.
module dmem_starve_counter import dmem_arb_pkg::*; #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == CW'(STARVE_MAX));

  // Clear wins over increment; increment stops at STARVE_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (combinational,
// stallable) and a loader port (req/ack, registered response).
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              ld_elig, gnt_ld, gnt_cpu, at_max;
  sel_t              sel;

  // The loader is only forced ahead of a CPU request once it has lost
  // STARVE_MAX times in a row; otherwise the CPU keeps zero-latency access.
  assign ld_elig = ld_req & (state_q == IDLE);
  assign gnt_ld  = ld_elig & (~cpu_req | at_max);
  assign gnt_cpu = cpu_req & ~gnt_ld;
  assign sel     = gnt_ld ? SEL_LD : (gnt_cpu ? SEL_CPU : SEL_NONE);

  assign cpu_stall = cpu_req & gnt_ld;
  assign cpu_rdata = (gnt_cpu & ~cpu_we) ? mem_read_data : '0;
  assign ld_ack    = (state_q == LD_RESP);
  assign ld_rdata  = ld_rdata_q;

  dmem_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (gnt_ld),
    .inc    (ld_elig & ~gnt_ld),
    .at_max (at_max)
  );

  // Memory port mux; an idle cycle drives all-zero command.
  always_comb begin
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (sel)
      SEL_CPU: begin
        mem_MemRead    = ~cpu_we;
        mem_MemWrite   = cpu_we;
        mem_address    = cpu_addr;
        mem_write_data = cpu_wdata;
      end
      SEL_LD: begin
        mem_MemRead    = ~ld_we;
        mem_MemWrite   = ld_we;
        mem_address    = ld_addr;
        mem_write_data = ld_wdata;
      end
      default: ;
    endcase
  end

  // Loader FSM: capture response on grant, ack for one cycle, back to IDLE.
  always_comb begin
    state_d    = state_q;
    ld_rdata_d = ld_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_ld) begin
          state_d    = LD_RESP;
          ld_rdata_d = ld_we ? '0 : mem_read_data;
        end
      end
      LD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a word-addressed data memory behind it.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ld_req, ld_we;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        ld_ack;
  logic        mem_MemRead, mem_MemWrite;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Data memory: 256 words, combinational read, write on the rising edge.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  assign mem_read_data = mem[mem_address[9:2]];
  always @(posedge clk) if (mem_MemWrite) mem[mem_address[9:2]] <= mem_write_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every ack pops the response expected when the request was issued.
  always @(negedge clk) begin
    if (rst_n && ld_ack) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL ld_ack_unexpected: got ack with empty scoreboard, expected none");
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("ld_rdata", ld_rdata, e);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one loader command, measure cycles to ack, drop req after the ack cycle.
  task automatic ld_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp, output int lat);
    ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
    sb.push_back(exp);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ld_ack) begin lat = c; break; end
      step();
    end
    if (lat >= 0 && !cpu_req)
      chk("ld_resp_mem_idle", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    step();
    ld_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_rd;
    logic        exp_wr;
  } cpu_vec_t;

  cpu_vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nst, st_c, ack_c;

    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h14, 32'hA5A55A5A, 32'h0,        1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h14, 32'h0,        32'hA5A55A5A, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h18, 32'h0,        32'h0,        1'b1, 1'b0};

    // Reset with both ports requesting: CPU must still not be stalled.
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = '0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0; ld_wdata = '0;
    @(negedge clk);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_ld_ack", {31'd0, ld_ack}, 32'd0);
    cpu_req = 1'b0; ld_req = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_mem_en", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    chk("idle_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("idle_ld_ack", {31'd0, ld_ack}, 32'd0);
    chk("idle_ld_rdata", ld_rdata, 32'd0);
    step();

    // CPU-only table: zero-latency reads and writes.
    foreach (vecs[i]) begin
      cpu_req = 1'b1; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      @(negedge clk);
      chk($sformatf("cpu_rdata[%0d]", i), cpu_rdata, vecs[i].exp_rdata);
      chk($sformatf("cpu_stall[%0d]", i), {31'd0, cpu_stall}, 32'd0);
      chk($sformatf("mem_rd[%0d]", i), {31'd0, mem_MemRead}, {31'd0, vecs[i].exp_rd});
      chk($sformatf("mem_wr[%0d]", i), {31'd0, mem_MemWrite}, {31'd0, vecs[i].exp_wr});
      chk($sformatf("mem_addr[%0d]", i), mem_address, vecs[i].addr);
      step();
    end
    cpu_req = 1'b0;

    // Loader alone: write then read back, ack one cycle after each grant.
    ld_xact(1'b1, 32'h40, 32'h12345678, 32'h0, lat);
    chk("ld_wr_latency", lat, 32'd1);
    ld_xact(1'b0, 32'h40, 32'h0, 32'h12345678, lat);
    chk("ld_rd_latency", lat, 32'd1);

    // Continuous CPU reads vs. loader read: 4 CPU wins, one stall, ack at +5.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
    sb.push_back(32'h12345678);
    nst = 0; st_c = -1; ack_c = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cpu_stall) begin nst++; st_c = c; end
      else chk("starve_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      if (ld_ack && ack_c < 0) ack_c = c;
      step();
      if (c == ack_c) ld_req = 1'b0;
    end
    cpu_req = 1'b0;
    chk("starve_stall_count", nst, 32'd1);
    chk("starve_stall_cycle", st_c, 32'd4);
    chk("starve_ack_cycle", ack_c, 32'd5);

    // Same-cycle writes to 0x20 with the count at max: loader first, CPU next.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h20; ld_wdata = 32'h11112222;
    sb.push_back(32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wr_build_stall", {31'd0, cpu_stall}, 32'd0);
      step();
    end
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h33334444;
    @(negedge clk);
    chk("wr_ld_stall", {31'd0, cpu_stall}, 32'd1);
    chk("wr_ld_data", mem_write_data, 32'h11112222);
    chk("wr_ld_addr", mem_address, 32'h20);
    step();
    @(negedge clk);
    chk("wr_ld_committed", mem[8], 32'h11112222);
    chk("wr_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("wr_cpu_data", mem_write_data, 32'h33334444);
    chk("wr_cpu_en", {31'd0, mem_MemWrite}, 32'd1);
    step();
    ld_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    chk("wr_final_read", cpu_rdata, 32'h33334444);
    step();
    cpu_req = 1'b0;

    // Reset pulse during the ack cycle aborts the response.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h20;
    sb.push_back(32'h33334444);
    @(negedge clk);
    chk("rst_ld_grant", {31'd0, mem_MemRead}, 32'd1);
    @(posedge clk); #2;
    chk("rst_pre_ack", {31'd0, ld_ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_ack_clear", {31'd0, ld_ack}, 32'd0);
    chk("rst_rdata_clear", ld_rdata, 32'd0);
    sb.delete();
    ld_req = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state_idle", {31'd0, dut.state_q}, {31'd0, IDLE});
    chk("rst_starve_zero", 32'(dut.u_starve.cnt_q), 32'd0);
    step();

    // Count built to 2 then cleared by reset.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
    step(); step();
    chk("cnt_built", 32'(dut.u_starve.cnt_q), 32'd2);
    rst_n = 1'b0; cpu_req = 1'b0; ld_req = 1'b0;
    #1;
    chk("cnt_rst_clear", 32'(dut.u_starve.cnt_q), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port data memory between the MIPS pipeline MEM stage (CPU port) and a program/data loader or debug port (LD port). The CPU port has zero-latency combinational access and a stall output. The loader uses a req/ack handshake with a registered response. An anti-starvation counter guarantees the loader a slot after a bounded number of CPU wins. The block sits between the MEM stage, the loader, and the data memory.

## Interface
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: byte-address width; the memory indexes word address bits [9:2].
- `STARVE_MAX`, 4: maximum consecutive denied loader cycles before the loader is forced ahead of the CPU; must be ≥1.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `cpu_req`  in  1: MEM-stage access this cycle.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W: byte address.
- `cpu_wdata`  in  DATA_W: write data.
- `cpu_rdata`  out  DATA_W: read data; combinational.
- `cpu_stall`  out  1: CPU request denied this cycle; pipeline holds.
- `ld_req`  in  1: loader request; held until `ld_ack`.
- `ld_we`, `ld_addr`, `ld_wdata`  in  1/ADDR_W/DATA_W: loader command; stable while `ld_req` is high.
- `ld_ack`  out  1: one-cycle pulse, the cycle after the loader access.
- `ld_rdata`  out  DATA_W: registered read data, valid with `ld_ack`.
- `mem_MemRead`, `mem_MemWrite`  out  1: memory enables.
- `mem_address`  out  ADDR_W: memory address.
- `mem_write_data`  out  DATA_W: memory write data.
- `mem_read_data`  in  DATA_W: combinational memory read data.

## Operation
- FSM has two states:
  - `IDLE`: loader eligible.
  - `LD_RESP`: ack cycle; loader not eligible.
- Loader eligibility: `ld_elig = ld_req & (state==IDLE)`.
- Grant, combinational, one per cycle:
  - `gnt_ld = ld_elig & (!cpu_req | starve_cnt==STARVE_MAX)`
  - `gnt_cpu = cpu_req & !gnt_ld`
- Memory mux:
  - Granted port drives `mem_address` and `mem_write_data`.
  - `mem_MemWrite = we`, `mem_MemRead = !we`.
  - With no grant, both enables are 0 and address/data are 0.
- `cpu_stall = cpu_req & gnt_ld`.
- `cpu_rdata = mem_read_data` when `gnt_cpu & !cpu_we`, else 0.
- `starve_cnt` (width `$clog2(STARVE_MAX+1)`) per cycle:
  - Set to 0 when `gnt_ld`.
  - Incremented, saturating at STARVE_MAX, when `ld_elig & !gnt_ld`.
  - Held otherwise.
- On `gnt_ld`: state → `LD_RESP`; `ld_rdata` ← `mem_read_data` for a read, or 0 for a write.
- `LD_RESP` → `IDLE` unconditionally. `ld_ack` = (state==`LD_RESP`).
- A loader write and a CPU write never reach memory in the same cycle.
- Writes happen in memory on the edge that ends the grant cycle.

## Timing
- Reset values: state `IDLE`, `starve_cnt` 0, `ld_ack` 0, `ld_rdata` 0.
- Combinational outputs under reset follow `IDLE` with count 0, so the CPU is never stalled.
- CPU latency: 0 cycles. Read data and write commit are in the request cycle unless stalled.
- Loader latency: request at cycle t with CPU idle → access in t, `ld_ack` in t+1.
- Loader worst case under continuous CPU traffic: access in t+STARVE_MAX, `ld_ack` in t+STARVE_MAX+1.
- The loader drops `ld_req`, or presents a new command, in the cycle after seeing `ld_ack`. Maximum loader throughput is one access per 2 cycles.
- `ld_req` still high during the `LD_RESP` cycle is ignored.
- CPU stall lasts exactly 1 cycle per forced loader grant. The CPU gets at least STARVE_MAX grants between stalls.
- Asynchronous reset mid-transaction aborts any pending ack. A loader write granted before reset is committed; the loader must reissue its request.
- Simultaneous requests with `starve_cnt` < STARVE_MAX: the CPU wins and the count increments.

## Structure
- Package `dmem_arb_pkg`:
  - State enum `arb_state_t {IDLE, LD_RESP}`.
  - Default `DATA_W` and `ADDR_W` localparams.
  - Port-select constants `SEL_NONE`, `SEL_CPU`, `SEL_LD`.
- Sub-module `dmem_starve_counter`: saturating counter with `clr`, `inc`, and `at_max` output, parameterised by STARVE_MAX.
- Grant, mux, and FSM live in `dmem_arbiter` itself.
- The bench instantiates the arbiter with the existing data memory behind it.

## Test plan
- Reset is released with no requests:
  - Memory enables stay 0 and `cpu_stall`=0.
  - `ld_ack`=0 and `ld_rdata`=0.
- CPU write 0xDEADBEEF to 0x10, then CPU read 0x10 the next cycle:
  - `cpu_rdata`=0xDEADBEEF in that same cycle.
  - `cpu_stall` never asserted.
- Loader alone writes 0x12345678 to 0x40, then reads 0x40:
  - `ld_ack` is 1 cycle after each grant.
  - `ld_rdata` with the second ack is 0x12345678.
  - The second request is granted no earlier than the cycle after the first ack.
- CPU requests every cycle, loader reads 0x40 with STARVE_MAX=4:
  - 4 CPU grants, then `cpu_stall`=1 for exactly 1 cycle while the loader is granted.
  - `ld_ack` comes 5 cycles after `ld_req` rose.
- Same-cycle CPU write and loader write to 0x20 with `starve_cnt` at max:
  - Loader data is written first, CPU write commits the next cycle.
  - A final read returns the CPU data.
- `rst_n` pulsed low during `LD_RESP`:
  - `ld_ack` and `ld_rdata` clear immediately.
  - State is `IDLE` and `starve_cnt` 0 after release.
